// File: rtl/norm_collector_pkg.sv
// Shared constants and types for the core / normalizer / collector slice.
//   NORM_COL_DEFAULT      default number of normalized words per row
//   NORM_BW_PSUM_DEFAULT  default width of one normalized word
//   norm_coll_state_t     collector FSM state (FILL / COMMIT)
package norm_collector_pkg;

    localparam int unsigned NORM_COL_DEFAULT     = 8;
    localparam int unsigned NORM_BW_PSUM_DEFAULT = 11;

    typedef enum logic {
        StFill   = 1'b0,
        StCommit = 1'b1
    } norm_coll_state_t;

endpackage

// File: rtl/norm_row_fifo.sv
// Row buffer for norm_collector: DEPTH slots of WIDTH bits, first-in first-out.
// Ports:
//   i_clk, i_reset   clock, asynchronous active-high reset (clears pointers)
//   i_push, i_wdata  write request and row; ignored when full unless i_pop is also accepted
//   i_pop            read request; ignored when empty
//   o_rdata          oldest row, zero while empty
//   o_full, o_empty  occupancy flags
module norm_row_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 88
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] PtrOne = {{AW{1'b0}}, 1'b1};

    logic [WIDTH-1:0] r_mem [DEPTH];
    // Extra MSB on each pointer distinguishes full from empty.
    logic [AW:0]      r_wptr;
    logic [AW:0]      r_rptr;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty   = (r_wptr == r_rptr);
    assign o_full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_do_pop  = i_pop && !o_empty;
    // A pop in the same cycle frees the slot, so a push on full still lands.
    assign w_do_push = i_push && (!o_full || w_do_pop);
    assign o_rdata   = o_empty ? '0 : r_mem[r_rptr[AW-1:0]];

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + PtrOne;
            if (w_do_pop)  r_rptr <= r_rptr + PtrOne;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_do_push) r_mem[r_wptr[AW-1:0]] <= i_wdata;
    end

endmodule

// File: rtl/norm_collector.sv
// Collects a stream of normalized words into COL-wide rows and hands them to a
// valid/ready consumer through a DEPTH-row buffer. The upstream cannot stall, so
// a completed row that finds the buffer full (and not draining) is dropped.
// Ports:
//   clk, reset             clock, asynchronous active-high reset
//   norm_valid, psum_norm  one normalized word per valid cycle
//   flush                  abandon the partial row (buffered rows survive)
//   m_valid, m_ready       row handshake; m_data holds word k at [k*BW_PSUM +: BW_PSUM]
//   overflow               sticky, a completed row was dropped
//   drop_cnt               dropped-row count, saturating at 255; only built when
//                          NORM_COLLECT_DROPCNT_EN is defined, otherwise tied to 0
module norm_collector
    import norm_collector_pkg::*;
#(
    parameter int unsigned COL     = NORM_COL_DEFAULT,
    parameter int unsigned BW_PSUM = NORM_BW_PSUM_DEFAULT,
    parameter int unsigned DEPTH   = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   norm_valid,
    input  logic [BW_PSUM-1:0]     psum_norm,
    input  logic                   flush,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic [BW_PSUM*COL-1:0] m_data,
    output logic                   overflow,
    output logic [7:0]             drop_cnt
);

    localparam int unsigned IW    = (COL > 1) ? $clog2(COL) : 1;
    localparam int unsigned ROW_W = BW_PSUM * COL;

    norm_coll_state_t              r_state;
    norm_coll_state_t              w_state_d;
    logic [IW-1:0]                 r_idx;
    logic [IW-1:0]                 w_idx_d;
    // Lanes 0..COL-2 only; the last word goes straight into the commit register.
    logic [BW_PSUM*(COL-1)-1:0]    r_stage;
    // Second staging level: frees r_stage for the next row during COMMIT.
    logic [ROW_W-1:0]              r_commit_row;
    logic                          r_overflow;
    logic                          w_accept;
    logic                          w_last;
    logic                          w_push;
    logic                          w_pop;
    logic                          w_drop;
    logic                          w_full;
    logic                          w_empty;

    assign w_accept = norm_valid && !flush;
    assign w_last   = w_accept && (r_idx == IW'(COL - 1));

    always_comb begin
        w_state_d = r_state;
        w_idx_d   = r_idx;
        w_push    = 1'b0;
        unique case (r_state)
            StFill: ;
            StCommit: begin
                w_push    = !flush;
                w_state_d = StFill;
            end
        endcase
        if (w_accept) begin
            if (w_last) begin
                w_idx_d   = '0;
                w_state_d = StCommit;
            end else begin
                w_idx_d = r_idx + IW'(1);
            end
        end
        if (flush) begin
            w_idx_d   = '0;
            w_state_d = StFill;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= StFill;
            r_idx        <= '0;
            r_stage      <= '0;
            r_commit_row <= '0;
        end else begin
            r_state <= w_state_d;
            r_idx   <= w_idx_d;
            for (int unsigned k = 0; k < COL - 1; k++) begin
                if (w_accept && (r_idx == IW'(k))) begin
                    r_stage[k*BW_PSUM +: BW_PSUM] <= psum_norm;
                end
            end
            if (w_last) r_commit_row <= {psum_norm, r_stage};
        end
    end

    assign w_pop  = m_valid && m_ready;
    assign w_drop = w_push && w_full && !w_pop;

    norm_row_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ROW_W)
    ) u_row_fifo (
        .i_clk   (clk),
        .i_reset (reset),
        .i_push  (w_push),
        .i_wdata (r_commit_row),
        .i_pop   (w_pop),
        .o_rdata (m_data),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign m_valid = !w_empty;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end
    end

    assign overflow = r_overflow;

`ifdef NORM_COLLECT_DROPCNT_EN
    logic [7:0] r_drop_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_drop_cnt <= '0;
        end else if (w_drop && (r_drop_cnt != 8'hFF)) begin
            r_drop_cnt <= r_drop_cnt + 8'd1;
        end
    end

    assign drop_cnt = r_drop_cnt;
`else
    assign drop_cnt = '0;
`endif

endmodule

// File: tb/tb_norm_collector.sv
// Self-checking bench for norm_collector: directed scenarios plus randomized
// traffic, all compared against a queue-based row model.
module tb_norm_collector;

    localparam int COL   = 8;
    localparam int BW    = 11;
    localparam int DEPTH = 4;
    localparam int W     = COL * BW;

    logic          clk = 1'b0;
    logic          reset;
    logic          norm_valid;
    logic [BW-1:0] psum_norm;
    logic          flush;
    logic          m_valid;
    logic          m_ready;
    logic [W-1:0]  m_data;
    logic          overflow;
    logic [7:0]    drop_cnt;

    always #5 clk = ~clk;

    norm_collector #(
        .COL     (COL),
        .BW_PSUM (BW),
        .DEPTH   (DEPTH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .norm_valid (norm_valid),
        .psum_norm  (psum_norm),
        .flush      (flush),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .overflow   (overflow),
        .drop_cnt   (drop_cnt)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [BW-1:0] lane(input logic [W-1:0] d, input int k);
        return d[k*BW +: BW];
    endfunction

    // Reference model: rows as whole values in a queue.
    logic [W-1:0]  q[$];
    logic [BW-1:0] stg[COL];
    int            m_idx;
    bit            m_pend;
    logic [W-1:0]  m_pend_row;
    bit            m_ovf;
    int            m_cnt;
    string         phase;

    task automatic model_reset();
        q.delete();
        m_idx  = 0;
        m_pend = 0;
        m_ovf  = 0;
        m_cnt  = 0;
    endtask

    task automatic model_edge(input bit nv, input logic [BW-1:0] w, input bit fl, input bit rdy);
        bit           pop;
        bit           full;
        bit           new_pend;
        logic [W-1:0] row;
        pop      = (q.size() > 0) && rdy;
        full     = (q.size() == DEPTH);
        new_pend = 0;
        if (pop) void'(q.pop_front());
        if (m_pend && !fl) begin
            if (!full || pop) begin
                q.push_back(m_pend_row);
            end else begin
                m_ovf = 1;
`ifdef NORM_COLLECT_DROPCNT_EN
                if (m_cnt < 255) m_cnt++;
`endif
            end
        end
        if (nv && !fl) begin
            stg[m_idx] = w;
            if (m_idx == COL - 1) begin
                for (int k = 0; k < COL; k++) row[k*BW +: BW] = stg[k];
                m_pend_row = row;
                new_pend   = 1;
                m_idx      = 0;
            end else begin
                m_idx++;
            end
        end
        if (fl) m_idx = 0;
        m_pend = new_pend;
    endtask

    task automatic compare();
        check({phase, ".m_valid"}, m_valid, q.size() > 0);
        if (q.size() > 0) check({phase, ".m_data"}, m_data, q[0]);
        check({phase, ".overflow"}, overflow, m_ovf);
        check({phase, ".drop_cnt"}, drop_cnt, m_cnt);
    endtask

    // One clock: compare at the falling edge, drive, then advance the model at the rise.
    task automatic step(input bit nv, input logic [BW-1:0] w, input bit fl, input bit rdy);
        @(negedge clk);
        compare();
        norm_valid = nv;
        psum_norm  = w;
        flush      = fl;
        m_ready    = rdy;
        @(posedge clk);
        model_edge(nv, w, fl, rdy);
        #1;
    endtask

    task automatic reset_dut();
        reset      = 1'b1;
        norm_valid = 1'b0;
        flush      = 1'b0;
        m_ready    = 1'b0;
        psum_norm  = '0;
        @(posedge clk);
        #1;
        check("rst.m_valid", m_valid, 0);
        check("rst.m_data", m_data, 0);
        check("rst.overflow", overflow, 0);
        check("rst.drop_cnt", drop_cnt, 0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        phase = "init";
        reset_dut();

        // Words 1..8: m_valid two clocks after the last word.
        phase = "basic";
        for (int i = 1; i <= 8; i++) step(1, BW'(i), 0, 0);
        check("basic.commit_gap", m_valid, 0);
        step(0, 0, 0, 0);
        check("basic.latency", m_valid, 1);
        for (int k = 0; k < COL; k++) check("basic.lane", lane(m_data, k), W'(k + 1));
        step(0, 0, 0, 1);
        step(0, 0, 0, 0);

        // 40 words with no drain: four rows kept, fifth dropped.
        phase = "ovf";
        reset_dut();
        for (int i = 1; i <= 40; i++) step(1, BW'(i), 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        check("ovf.overflow", overflow, 1);
`ifdef NORM_COLLECT_DROPCNT_EN
        check("ovf.drop_cnt", drop_cnt, 1);
`else
        check("ovf.drop_cnt", drop_cnt, 0);
`endif
        for (int r = 0; r < 4; r++) begin
            check("ovf.valid", m_valid, 1);
            check("ovf.lane0", lane(m_data, 0), W'(8 * r + 1));
            check("ovf.lane7", lane(m_data, 7), W'(8 * r + 8));
            step(0, 0, 0, 1);
        end
        check("ovf.drained", m_valid, 0);

        // Full buffer, pop during COMMIT: push accepted, no drop.
        phase = "fullpop";
        reset_dut();
        for (int i = 1; i <= 40; i++) step(1, BW'(i), 0, 0);
        step(0, 0, 0, 1);
        step(0, 0, 0, 0);
        check("fullpop.overflow", overflow, 0);
        check("fullpop.drop_cnt", drop_cnt, 0);
        for (int r = 1; r < 5; r++) begin
            check("fullpop.lane0", lane(m_data, 0), W'(8 * r + 1));
            step(0, 0, 0, 1);
        end
        check("fullpop.drained", m_valid, 0);

        // Partial row flushed; flush-cycle word ignored.
        phase = "flush";
        reset_dut();
        for (int i = 1; i <= 3; i++) step(1, BW'(i), 0, 1);
        step(1, 11'h055, 1, 1);
        for (int i = 0; i < 8; i++) step(1, BW'(16 + i), 0, 0);
        step(0, 0, 0, 0);
        check("flush.valid", m_valid, 1);
        for (int k = 0; k < COL; k++) check("flush.lane", lane(m_data, k), W'(16 + k));
        step(0, 0, 0, 1);
        step(0, 0, 0, 0);
        check("flush.single_row", m_valid, 0);

        // Reset mid-row with two rows buffered.
        phase = "midrst";
        reset_dut();
        for (int i = 1; i <= 16; i++) step(1, BW'(i), 0, 0);
        step(0, 0, 0, 0);
        for (int i = 1; i <= 5; i++) step(1, BW'(100 + i), 0, 0);
        check("midrst.pre", m_valid, 1);
        reset = 1'b1;
        #1;
        check("midrst.m_valid", m_valid, 0);
        check("midrst.m_data", m_data, 0);
        model_reset();
        @(negedge clk);
        reset      = 1'b0;
        norm_valid = 1'b0;
        for (int i = 0; i < 8; i++) step(1, BW'(32 + i), 0, 0);
        step(0, 0, 0, 0);
        for (int k = 0; k < COL; k++) check("midrst.lane", lane(m_data, k), W'(32 + k));
        step(0, 0, 0, 1);

        // Negative word passes untouched.
        phase = "neg";
        for (int k = 0; k < COL; k++) step(1, (k == 3) ? 11'h7FF : BW'(k), 0, 0);
        step(0, 0, 0, 0);
        check("neg.bits43_33", m_data[43:33], 11'h7FF);
        check("neg.lane4", lane(m_data, 4), 4);
        step(0, 0, 0, 1);

        // Random traffic: sparse drain first to provoke drops, then balanced.
        phase = "rand";
        reset_dut();
        for (int i = 0; i < 3000; i++) begin
            step(($urandom % 10) < 7, BW'($urandom), ($urandom % 40) == 0,
                 (i < 1500) ? (($urandom % 4) == 0) : ($urandom % 2));
        end
        for (int i = 0; i < 12; i++) step(0, 0, 0, 1);
        @(negedge clk);
        compare();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/norm_collector.md
NORM_COLLECTOR -- requirements
Module: norm_collector

Interface
REQ-001 SHALL have parameter COL, default 8, number of normalized words per output row.
REQ-002 SHALL have parameter BW_PSUM, default 11, width of one normalized word.
REQ-003 SHALL have parameter DEPTH, default 4, number of row slots in the output buffer (power of 2, at least 2).
REQ-004 SHALL have port clk  input  1  single clock; all logic rising-edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port norm_valid  input  1  one normalized word present this cycle; the upstream cannot be stalled.
REQ-007 SHALL have port psum_norm  input  BW_PSUM  normalized word, signed two's complement.
REQ-008 SHALL have port flush  input  1  discard any partial row.
REQ-009 SHALL have port m_valid  output  1  row available at m_data.
REQ-010 SHALL have port m_ready  input  1  downstream accepts the row.
REQ-011 SHALL have port m_data  output  BW_PSUM*COL  packed row; word k sits at bits [k*BW_PSUM +: BW_PSUM].
REQ-012 SHALL have port overflow  output  1  sticky: a completed row was dropped.
REQ-013 SHALL have port drop_cnt  output  8  count of dropped rows.

Function
REQ-014 SHALL keep word index idx (0..COL-1); each norm_valid cycle writes psum_norm into staging lane idx and increments idx.
REQ-015 SHALL implement FSM states FILL and COMMIT: FILL while idx<COL-1; on norm_valid with idx==COL-1, go to COMMIT for exactly one cycle, then return to FILL with idx=0.
REQ-016 SHALL push the staged row into the buffer in the COMMIT cycle; m_valid SHALL rise on the cycle after COMMIT when the buffer was empty (latency 2 clocks from last word to m_valid).
REQ-017 SHALL accept norm_valid during COMMIT as word 0 of the next row with no bubble; staging SHALL be double-registered so the committing row is not corrupted.
REQ-018 SHALL transfer a row on every cycle with m_valid and m_ready high; m_data SHALL hold stable while m_valid is high and m_ready is low.
REQ-019 SHALL deliver rows in arrival order; read and write pointers wrap modulo DEPTH.
REQ-020 SHALL, when full and a pop occurs in the COMMIT cycle, accept the push (simultaneous push/pop on full is not a drop).
REQ-021 SHALL, when full with no pop in the COMMIT cycle, discard the committed row, set overflow, and leave buffered rows intact.
REQ-022 SHALL, on flush, set idx to 0 and cancel a pending COMMIT; buffered rows are kept; norm_valid in the same cycle as flush is ignored.
REQ-023 SHALL pass word bits unmodified (no sign extension or rounding).

Reset
REQ-024 SHALL, on reset assertion, immediately clear idx, FSM (to FILL), pointers, m_valid, overflow and drop_cnt; m_data SHALL be 0.
REQ-025 SHALL discard partial and buffered rows when reset is asserted mid-row; the first norm_valid after release is word 0.

Configuration
REQ-026 SHALL, with NORM_COLLECT_DROPCNT_EN defined, increment drop_cnt on each dropped row and saturate it at 255.
REQ-027 SHALL, without NORM_COLLECT_DROPCNT_EN, tie drop_cnt to 0 and synthesize no counter; overflow behaviour is unchanged.

Structure
REQ-028 SHALL take the shared package constants NORM_COL_DEFAULT and NORM_BW_PSUM_DEFAULT and the FSM state typedef norm_coll_state_t from the package also used by core and normalizer.
REQ-029 SHALL place the row buffer in one sub-module, norm_row_fifo (push/pop/full/empty, DEPTH x BW_PSUM*COL).

Verification
REQ-030 SHALL check: 8 consecutive norm_valid with words 1..8, m_ready=1 -> m_valid high 2 clocks after word 8; m_data lane0=1 ... lane7=8.
REQ-031 SHALL check: 40 back-to-back words, m_ready=0 -> 4 rows buffered, 5th row dropped, overflow=1, drop_cnt=1 (macro on) / 0 (macro off); then m_ready=1 drains rows 1-4 in order.
REQ-032 SHALL check: buffer full, m_ready=1 in the COMMIT cycle -> no drop, overflow stays 0.
REQ-033 SHALL check: 3 words, flush, then words 0x10..0x17 -> one row with lane0=0x10, no stale data.
REQ-034 SHALL check: reset asserted after word 5 of a row, with 2 rows buffered -> m_valid=0 at once, next 8 words form the first row.
REQ-035 SHALL check: negative word 0x7FF (-1) in lane 3 -> m_data bits [43:33] = 0x7FF exactly.
